// File: rtl/calc_pkg.sv
// Shared definitions for the calculator command sequencer.
//   - default operand/result width
//   - FSM state encodings
//   - layout of a packed command word {clear, sel[2:0], data[DATA_W-1:0]}
package calc_pkg;

    localparam int DATA_W_DEFAULT = 16;
    localparam int SEL_W          = 3;
    localparam int CMD_CTRL_W     = SEL_W + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_HOLD    = 3'd2;
    localparam logic [2:0] S_STROBE  = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_RESP    = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_LOAD    = S_LOAD,
        ST_HOLD    = S_HOLD,
        ST_STROBE  = S_STROBE,
        ST_CAPTURE = S_CAPTURE,
        ST_RESP    = S_RESP
    } state_t;

    // Packed command word width for a given operand width.
    function automatic int cmd_w(input int data_w);
        return data_w + CMD_CTRL_W;
    endfunction

    // LSB of the sel field; sel sits directly above the operand.
    function automatic int sel_lsb(input int data_w);
        return data_w;
    endfunction

    // Position of the clear flag (MSB of the command word).
    function automatic int clear_bit(input int data_w);
        return data_w + SEL_W;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointer full/empty detection.
// Ports:
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_push_valid      write request; accepted when o_push_ready
//   o_push_ready      FIFO not full (purely a function of stored pointers)
//   i_push_data       write data
//   i_pop             read request; ignored when empty
//   o_empty           FIFO empty
//   o_head            oldest entry (valid when !o_empty)
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push_valid,
    output logic             o_push_ready,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_full       = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_empty      = (r_wptr == r_rptr);
    // A pop in the same cycle does not open a slot until the next cycle.
    assign o_push_ready = !w_full;
    assign w_push       = i_push_valid && !w_full;
    assign w_pop        = i_pop && !o_empty;
    assign o_head       = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/calc_sequencer.sv
// Command scheduler in front of the button/switch calculator. Queues
// {clear, sel, operand} commands, plays each one onto the calculator's
// button/switch inputs and returns the resulting accumulator value.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake (ready = FIFO not full)
//   cmd_clear, cmd_sel, cmd_data  command fields
//   rsp_valid/rsp_ready/rsp_data  accumulator result after each command
//   busy                          work queued or in flight
//   calc_btnc/l/r, calc_sw        op select and operand to the calculator
//   calc_btnu, calc_btnd          accumulator clear / update strobes
//   calc_led                      accumulator value from the calculator
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | wait for a queued command; pop it into the command register
// LOAD    | present sel/operand to the calculator
// HOLD    | keep sel/operand stable for SETTLE extra cycles
// STROBE  | one-cycle update (btnd) or clear (btnu) pulse
// CAPTURE | accumulator has updated; sample calc_led
// RESP    | offer the result until the consumer takes it
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_clear,
    input  logic [2:0]        cmd_sel,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              calc_btnc,
    output logic              calc_btnl,
    output logic              calc_btnr,
    output logic              calc_btnu,
    output logic              calc_btnd,
    output logic [DATA_W-1:0] calc_sw,
    input  logic [DATA_W-1:0] calc_led
);

    localparam int CMD_W = cmd_w(DATA_W);
    localparam int CLR_B = clear_bit(DATA_W);
    localparam int SEL_L = sel_lsb(DATA_W);
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CMD_W-1:0]  r_cmd;
    logic [CNT_W-1:0]  r_hold_cnt;
    logic [DATA_W-1:0] r_rsp_data;

    logic [CMD_W-1:0]  w_cmd_in;
    logic [CMD_W-1:0]  w_head;
    logic              w_fifo_empty;
    logic              w_pop;
    logic              w_clr;
    logic [SEL_W-1:0]  w_sel;
    logic [DATA_W-1:0] w_data;

    assign w_cmd_in = {cmd_clear, cmd_sel, cmd_data};
    assign w_clr    = r_cmd[CLR_B];
    assign w_sel    = r_cmd[SEL_L +: SEL_W];
    assign w_data   = r_cmd[DATA_W-1:0];

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .i_clk        (clk),
        .i_rst_n      (reset_n),
        .i_push_valid (cmd_valid),
        .o_push_ready (cmd_ready),
        .i_push_data  (w_cmd_in),
        .i_pop        (w_pop),
        .o_empty      (w_fifo_empty),
        .o_head       (w_head)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   r_cmd <= '0;
        else if (w_pop) r_cmd <= w_head;
    end

    // Down-counter: loaded in LOAD, HOLD exits on terminal count zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_hold_cnt <= '0;
        else if (r_state == ST_LOAD)
            r_hold_cnt <= HOLD_LOAD;
        else if (r_state == ST_HOLD && r_hold_cnt != '0)
            r_hold_cnt <= r_hold_cnt - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                   r_rsp_data <= '0;
        else if (r_state == ST_CAPTURE) r_rsp_data <= calc_led;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        calc_btnc   = 1'b0;
        calc_btnl   = 1'b0;
        calc_btnr   = 1'b0;
        calc_btnu   = 1'b0;
        calc_btnd   = 1'b0;
        calc_sw     = '0;
        rsp_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                {calc_btnc, calc_btnl, calc_btnr} = w_sel;
                calc_sw     = w_data;
                w_state_nxt = (SETTLE == 0) ? ST_STROBE : ST_HOLD;
            end
            ST_HOLD: begin
                {calc_btnc, calc_btnl, calc_btnr} = w_sel;
                calc_sw = w_data;
                if (r_hold_cnt == '0) w_state_nxt = ST_STROBE;
            end
            ST_STROBE: begin
                // A clear pulses btnu alone with op/operand released.
                if (w_clr) begin
                    calc_btnu = 1'b1;
                end else begin
                    {calc_btnc, calc_btnl, calc_btnr} = w_sel;
                    calc_sw   = w_data;
                    calc_btnd = 1'b1;
                end
                w_state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign rsp_data = r_rsp_data;
    assign busy     = !w_fifo_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 16;
    localparam int SETTLE = 1;
    localparam int TRC    = SETTLE + 6;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_clear;
    logic [2:0]        cmd_sel;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;
    logic              calc_btnc, calc_btnl, calc_btnr, calc_btnu, calc_btnd;
    logic [DATA_W-1:0] calc_sw;
    logic [DATA_W-1:0] calc_led;
    logic [DATA_W-1:0] calc_acc = '0;

    int tests = 0;
    int fails = 0;
    int n_btnd = 0;
    int n_btnu = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] model_acc;
    logic rand_rdy  = 1'b0;
    logic rdy_fixed = 1'b1;

    logic [2:0]        t_sel  [TRC];
    logic [DATA_W-1:0] t_sw   [TRC];
    logic              t_d    [TRC];
    logic              t_u    [TRC];
    logic              t_v    [TRC];
    logic              t_busy [TRC];
    logic [DATA_W-1:0] t_rd   [TRC];

    always #5 clk = ~clk;

    calc_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .SETTLE(SETTLE)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_clear (cmd_clear),
        .cmd_sel   (cmd_sel),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .calc_btnc (calc_btnc),
        .calc_btnl (calc_btnl),
        .calc_btnr (calc_btnr),
        .calc_btnu (calc_btnu),
        .calc_btnd (calc_btnd),
        .calc_sw   (calc_sw),
        .calc_led  (calc_led)
    );

    // Behavioural calculator operation for a {btnc,btnl,btnr} pattern.
    function automatic logic [DATA_W-1:0] calc_fn(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic [2:0] s);
        case (s)
            3'd0:    return b;
            3'd1:    return a - b;
            3'd2:    return a + b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a ^ b;
            3'd6:    return a << b[3:0];
            default: return a >> b[3:0];
        endcase
    endfunction

    // Stand-in calculator: accumulator is not tied to the sequencer reset.
    always @(posedge clk) begin
        if (calc_btnu)      calc_acc <= '0;
        else if (calc_btnd) calc_acc <= calc_fn(calc_acc, calc_sw, {calc_btnc, calc_btnl, calc_btnr});
    end
    assign calc_led = calc_acc;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_fixed;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops on every response handshake, plus strobe rules.
    initial begin
        logic prev_d, prev_u, prev_hold;
        logic [DATA_W-1:0] prev_data;
        logic [DATA_W-1:0] e;
        prev_d = 1'b0; prev_u = 1'b0; prev_hold = 1'b0; prev_data = '0;
        forever begin
            @(negedge clk);
            if (calc_btnd || calc_btnu) begin
                tests++;
                if (calc_btnd && calc_btnu) begin
                    fails++;
                    $display("FAIL strobe_overlap: btnd=%b btnu=%b required not both", calc_btnd, calc_btnu);
                end
            end
            if (calc_btnd) begin
                n_btnd++;
                tests++;
                if (prev_d) begin
                    fails++;
                    $display("FAIL btnd_width: high two cycles, required one");
                end
            end
            if (calc_btnu) begin
                n_btnu++;
                tests++;
                if (prev_u) begin
                    fails++;
                    $display("FAIL btnu_width: high two cycles, required one");
                end
            end
            if (prev_hold) begin
                tests++;
                if (!rsp_valid || rsp_data !== prev_data) begin
                    fails++;
                    $display("FAIL rsp_hold: valid=%b data=%h required valid=1 data=%h", rsp_valid, rsp_data, prev_data);
                end
            end
            if (rsp_valid && rsp_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL rsp_unexpected: data=%h with no command outstanding", rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_data !== e) begin
                        fails++;
                        $display("FAIL rsp_data: got %h expected %h", rsp_data, e);
                    end
                end
            end
            prev_hold = rsp_valid && !rsp_ready && reset_n;
            prev_data = rsp_data;
            prev_d    = calc_btnd;
            prev_u    = calc_btnu;
        end
    end

    // Offer one command; on acceptance the reference accumulator advances
    // and the expected response is queued.
    task automatic push_cmd(input logic clr, input logic [2:0] sel, input logic [DATA_W-1:0] data);
        logic ok;
        ok = 1'b0;
        cmd_valid = 1'b1; cmd_clear = clr; cmd_sel = sel; cmd_data = data;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
            model_acc = clr ? '0 : calc_fn(model_acc, data, sel);
            exp_q.push_back(model_acc);
        end else begin
            tests++;
            fails++;
            $display("FAIL push_timeout: cmd_ready=%b required 1 within 400 cycles", cmd_ready);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic trace_cmd(input logic clr, input logic [2:0] sel, input logic [DATA_W-1:0] data,
                             input logic [DATA_W-1:0] exp_data);
        logic drv;
        @(posedge clk);
        #1;
        push_cmd(clr, sel, data);
        for (int k = 0; k < TRC; k++) begin
            @(negedge clk);
            t_sel[k]  = {calc_btnc, calc_btnl, calc_btnr};
            t_sw[k]   = calc_sw;
            t_d[k]    = calc_btnd;
            t_u[k]    = calc_btnu;
            t_v[k]    = rsp_valid;
            t_busy[k] = busy;
            t_rd[k]   = rsp_data;
        end
        for (int k = 0; k < TRC; k++) begin
            drv = (k >= 1 && k <= 1 + SETTLE) || (k == 2 + SETTLE && !clr);
            chk($sformatf("tr_sel[%0d]", k),  32'(t_sel[k]),  32'(drv ? sel : 3'd0));
            chk($sformatf("tr_sw[%0d]", k),   32'(t_sw[k]),   32'(drv ? data : '0));
            chk($sformatf("tr_btnd[%0d]", k), 32'(t_d[k]),    32'(!clr && k == 2 + SETTLE));
            chk($sformatf("tr_btnu[%0d]", k), 32'(t_u[k]),    32'(clr && k == 2 + SETTLE));
            chk($sformatf("tr_rv[%0d]", k),   32'(t_v[k]),    32'(k == 4 + SETTLE));
            chk($sformatf("tr_busy[%0d]", k), 32'(t_busy[k]), 32'(k <= 4 + SETTLE));
            if (k == 4 + SETTLE) chk("tr_data", 32'(t_rd[k]), 32'(exp_data));
        end
    endtask

    task automatic wait_drain(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL %s: %0d responses outstanding busy=%b, required 0 and idle", name, exp_q.size(), busy);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_btnc"}, 32'(calc_btnc), 32'd0);
        chk({tag, "_btnl"}, 32'(calc_btnl), 32'd0);
        chk({tag, "_btnr"}, 32'(calc_btnr), 32'd0);
        chk({tag, "_btnu"}, 32'(calc_btnu), 32'd0);
        chk({tag, "_btnd"}, 32'(calc_btnd), 32'd0);
        chk({tag, "_sw"},   32'(calc_sw),   32'd0);
        chk({tag, "_rv"},   32'(rsp_valid), 32'd0);
        chk({tag, "_rd"},   32'(rsp_data),  32'd0);
        chk({tag, "_busy"}, 32'(busy),      32'd0);
        chk({tag, "_crdy"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] held;
        int nb, nu, nclr, nop, nv;
        logic clr;
        logic got;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_clear = 1'b0; cmd_sel = '0; cmd_data = '0;
        model_acc = '0;

        repeat (3) @(negedge clk);
        chk_idle_outputs("rst_in");
        reset_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs("rst_out");

        // Single command, add 5 to a zero accumulator.
        trace_cmd(1'b0, 3'b010, 16'h0005, 16'h0005);
        // Load 1234, then clear it.
        trace_cmd(1'b0, 3'b000, 16'h1234, 16'h1234);
        trace_cmd(1'b1, 3'b101, 16'hBEEF, 16'h0000);

        // Five back-to-back commands with the consumer ready.
        rdy_fixed = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) push_cmd(1'b0, 3'(i + 1), 16'(16'h0101 * (i + 3)));
        @(negedge clk);
        chk("burst_full_crdy", 32'(cmd_ready), 32'd0);
        chk("burst_busy", 32'(busy), 32'd1);
        wait_drain("burst_drain");

        // Consumer stalls: FIFO fills, response held, no further strobes.
        rdy_fixed = 1'b0;
        @(posedge clk); #2;
        for (int i = 0; i < 5; i++) push_cmd(1'b0, 3'd2, 16'(i * 7 + 1));
        @(negedge clk);
        chk("stall_full_crdy", 32'(cmd_ready), 32'd0);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("stall_rv_seen", 32'(got), 32'd1);
        held = rsp_data;
        nb = n_btnd;
        cmd_valid = 1'b1; cmd_clear = 1'b0; cmd_sel = 3'd2; cmd_data = 16'h7777;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_rv", 32'(rsp_valid), 32'd1);
            chk("stall_rd", 32'(rsp_data), 32'(held));
            chk("stall_crdy", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        chk("stall_no_btnd", 32'(n_btnd - nb), 32'd0);
        rdy_fixed = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin got = 1'b1; break; end
        end
        chk("stall_release", 32'(got), 32'd1);
        @(negedge clk);
        chk("crdy_before_pop", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("crdy_after_pop", 32'(cmd_ready), 32'd1);
        wait_drain("stall_drain");

        // Reset while a command is strobing; queued work is discarded.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) push_cmd(1'b0, 3'd2, 16'h0010);
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (calc_btnd) begin got = 1'b1; break; end
        end
        chk("rst_strobe_seen", 32'(got), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk_idle_outputs("rst_mid");
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) nv++;
        end
        chk("rst_no_rsp", 32'(nv), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        // Accumulator state after the reset is unknown to the model: clear it.
        trace_cmd(1'b1, 3'b011, 16'h00FF, 16'h0000);

        // Randomised stream with a randomly stalling consumer.
        nb = n_btnd; nu = n_btnu; nclr = 0; nop = 0;
        rand_rdy = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            clr = ($urandom_range(0, 7) == 0);
            if (clr) nclr++;
            else     nop++;
            push_cmd(clr, 3'($urandom_range(0, 7)), 16'($urandom));
        end
        wait_drain("rand_drain");
        rand_rdy = 1'b0;
        chk("rand_btnd_count", 32'(n_btnd - nb), 32'(nop));
        chk("rand_btnu_count", 32'(n_btnu - nu), 32'(nclr));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
